// File: rtl/mem_resp_queue_pkg.sv
// Shared definitions for the EX->WB memory response queue.
package mem_resp_queue_pkg;

    typedef enum logic [1:0] {
        LD_SIZE_B = 2'd0,
        LD_SIZE_H = 2'd1,
        LD_SIZE_W = 2'd2,
        LD_SIZE_D = 2'd3
    } ld_size_e;

    localparam int MS_PAY_WD = 200;

endpackage

// File: rtl/mem_resp_queue_ld_align.sv
// Combinational load aligner: picks the addressed bytes and sign/zero extends them.
module ld_align
    import mem_resp_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;
    logic              sign_bit;
    logic              ext_bit;
    int                nbits;

    always_comb begin
        shifted = data >> {offset, 3'b000};
        nbits   = 8 << size;
        case (size)
            LD_SIZE_B: sign_bit = shifted[7];
            LD_SIZE_H: sign_bit = shifted[15];
            LD_SIZE_W: sign_bit = shifted[31];
            default:   sign_bit = shifted[DATA_W-1];
        endcase
        ext_bit = is_unsigned ? 1'b0 : sign_bit;
        result  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            result[i] = (i < nbits) ? shifted[i] : ext_bit;
        end
    end

endmodule

// File: rtl/mem_resp_queue.sv
// In-order queue between EX and WB tracking outstanding loads; responses of
// flushed loads are swallowed by a cancel counter.
module mem_resp_queue
    import mem_resp_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PAY_W  = MS_PAY_WD,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 3,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [PAY_W-1:0]  es_payload,
    input  logic              es_is_load,
    input  logic [1:0]        es_ld_size,
    input  logic              es_ld_unsigned,
    input  logic [OFF_W-1:0]  es_addr_low,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    output logic              ms_to_ws_valid,
    input  logic              ws_allowin,
    output logic [PAY_W-1:0]  ms_payload,
    output logic [DATA_W-1:0] ms_ld_result,
    output logic [CNT_W-1:0]  ms_pending_cnt,
    output logic              ms_cancel_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, is_load_q, got_q, uns_q;
    logic [PAY_W-1:0]  pay_q  [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [OFF_W-1:0]  off_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] rd, wr, rp;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] pend_q, cancel_q;

    logic rp_found, full, enq, deq;
    logic cancel_zero, pend_zero;
    logic ok_cancel, ok_pend, ok_enq, enq_pend;
    logic head_load, bypass;
    logic [DATA_W-1:0] head_data, aligned;

    // rp is the first load still waiting for data, searched from the head
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = rd;
        rp       = rd;
        rp_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd + PTR_W'(i);
            if (!rp_found && valid_q[idx] && is_load_q[idx] && !got_q[idx]) begin
                rp       = idx;
                rp_found = 1'b1;
            end
        end
    end

    assign cancel_zero = (cancel_q == '0);
    assign pend_zero   = (pend_q == '0);
    assign full        = (occ == OCC_W'(DEPTH));

    assign ok_cancel = data_sram_data_ok && !cancel_zero;
    assign ok_pend   = data_sram_data_ok && cancel_zero && !pend_zero;
    assign ok_enq    = data_sram_data_ok && cancel_zero && pend_zero && enq && es_is_load;
    assign enq_pend  = enq && es_is_load && !ok_enq;

    assign head_load = valid_q[rd] && is_load_q[rd];
    assign bypass    = head_load && !got_q[rd] && ok_pend && rp_found && (rp == rd);

    assign ms_to_ws_valid = valid_q[rd] && (!is_load_q[rd] || got_q[rd] || bypass) && !flush;
    assign ms_allowin     = !full || (ms_to_ws_valid && ws_allowin);
    assign enq            = es_to_ms_valid && ms_allowin && !flush;
    assign deq            = ms_to_ws_valid && ws_allowin;

    assign head_data = got_q[rd] ? data_q[rd] : data_sram_rdata;

    ld_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_ld_align (
        .data        (head_data),
        .size        (size_q[rd]),
        .is_unsigned (uns_q[rd]),
        .offset      (off_q[rd]),
        .result      (aligned)
    );

    assign ms_payload     = pay_q[rd];
    assign ms_ld_result   = head_load ? aligned : '0;
    assign ms_pending_cnt = pend_q;
    assign ms_cancel_busy = !cancel_zero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= '0;
            is_load_q <= '0;
            got_q     <= '0;
            uns_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pay_q[i]  <= '0;
                size_q[i] <= '0;
                off_q[i]  <= '0;
                data_q[i] <= '0;
            end
            rd       <= '0;
            wr       <= '0;
            occ      <= '0;
            pend_q   <= '0;
            cancel_q <= '0;
        end else if (flush) begin
            valid_q  <= '0;
            rd       <= '0;
            wr       <= '0;
            occ      <= '0;
            pend_q   <= '0;
            // every still-pending load now owes one response to be discarded
            cancel_q <= cancel_q + pend_q - CNT_W'(ok_cancel || ok_pend);
        end else begin
            if (ok_cancel) cancel_q <= cancel_q - 1'b1;
            if (ok_pend) begin
                got_q[rp]  <= 1'b1;
                data_q[rp] <= data_sram_rdata;
            end
            if (deq) begin
                valid_q[rd] <= 1'b0;
                rd          <= rd + 1'b1;
            end
            // enqueue last so a full-queue replace of the head slot wins
            if (enq) begin
                valid_q[wr]   <= 1'b1;
                is_load_q[wr] <= es_is_load;
                got_q[wr]     <= ok_enq;
                uns_q[wr]     <= es_ld_unsigned;
                pay_q[wr]     <= es_payload;
                size_q[wr]    <= es_ld_size;
                off_q[wr]     <= es_addr_low;
                data_q[wr]    <= data_sram_rdata;
                wr            <= wr + 1'b1;
            end
            occ    <= occ + OCC_W'(enq) - OCC_W'(deq);
            pend_q <= pend_q + CNT_W'(enq_pend) - CNT_W'(ok_pend);
        end
    end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Scoreboard bench for mem_resp_queue: a 32-bit instance for queue behaviour, a 64-bit one for ld.d.
module tb_mem_resp_queue;
    import mem_resp_queue_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        es_valid, es_is_load, es_ld_unsigned, data_ok, flush, ws_allowin;
    logic [15:0] es_payload;
    logic [1:0]  es_ld_size, es_addr_low;
    logic [31:0] rdata;
    logic        ms_allowin, ms_to_ws_valid, ms_cancel_busy;
    logic [15:0] ms_payload;
    logic [31:0] ms_ld_result;
    logic [2:0]  ms_pending_cnt;

    mem_resp_queue #(.DATA_W(32), .PAY_W(16), .DEPTH(2), .CNT_W(3)) u_dut32 (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_valid), .ms_allowin(ms_allowin), .es_payload(es_payload),
        .es_is_load(es_is_load), .es_ld_size(es_ld_size), .es_ld_unsigned(es_ld_unsigned),
        .es_addr_low(es_addr_low), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .flush(flush), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_payload(ms_payload), .ms_ld_result(ms_ld_result),
        .ms_pending_cnt(ms_pending_cnt), .ms_cancel_busy(ms_cancel_busy)
    );

    logic        v64, ld64, un64, ok64, fl64, ws64;
    logic [15:0] pay64;
    logic [1:0]  sz64;
    logic [2:0]  off64;
    logic [63:0] rd64;
    logic        allow64, outv64, busy64;
    logic [15:0] opay64;
    logic [63:0] res64;
    logic [2:0]  pend64;

    mem_resp_queue #(.DATA_W(64), .PAY_W(16), .DEPTH(2), .CNT_W(3)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(v64), .ms_allowin(allow64), .es_payload(pay64),
        .es_is_load(ld64), .es_ld_size(sz64), .es_ld_unsigned(un64),
        .es_addr_low(off64), .data_sram_data_ok(ok64), .data_sram_rdata(rd64),
        .flush(fl64), .ms_to_ws_valid(outv64), .ws_allowin(ws64),
        .ms_payload(opay64), .ms_ld_result(res64),
        .ms_pending_cnt(pend64), .ms_cancel_busy(busy64)
    );

    typedef struct packed {
        logic [15:0] pay;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_res;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pay, input logic ld, input logic [1:0] sz,
                         input logic un, input logic [1:0] off, input logic [31:0] res);
        es_valid       = 1'b1;
        es_payload     = pay;
        es_is_load     = ld;
        es_ld_size     = sz;
        es_ld_unsigned = un;
        es_addr_low    = off;
        exp_res        = res;
    endtask

    // Model: flush/reset empties the queue; accepted inputs push, WB handshakes pop.
    always @(negedge clk) begin
        if (!resetn || flush) begin
            sb.delete();
        end else begin
            if (es_valid && ms_allowin) sb.push_back('{pay: es_payload, res: exp_res});
            if (ms_to_ws_valid && ws_allowin) begin
                if (sb.size() == 0) begin
                    check_val("pop_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_pops++;
                    check_val("sb_payload", 64'(ms_payload), 64'(e.pay));
                    check_val("sb_ld_result", 64'(ms_ld_result), 64'(e.res));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        es_valid = 0; es_is_load = 0; es_ld_unsigned = 0; es_ld_size = 0; es_addr_low = 0;
        es_payload = 0; data_ok = 0; flush = 0; ws_allowin = 1; rdata = 0; exp_res = 0;
        v64 = 0; ld64 = 0; un64 = 0; ok64 = 0; fl64 = 0; ws64 = 1; pay64 = 0; sz64 = 0;
        off64 = 0; rd64 = 0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(ms_to_ws_valid), 64'd0);
        check_val("rst_allowin", 64'(ms_allowin), 64'd1);
        check_val("rst_pending", 64'(ms_pending_cnt), 64'd0);
        check_val("rst_cancel", 64'(ms_cancel_busy), 64'd0);
        check_val("rst_result", 64'(ms_ld_result), 64'd0);
        #2 resetn = 1'b1;

        // ld.b offset 3, data two cycles later
        tick();
        drive(16'h0011, 1'b1, LD_SIZE_B, 1'b0, 2'd3, 32'hFFFF_FF80);
        tick();
        es_valid = 0;
        #1 check_val("ldb_pending1", 64'(ms_pending_cnt), 64'd1);
        tick();
        tick();
        data_ok = 1; rdata = 32'h80AB_CDEF;
        #1;
        check_val("ldb_valid", 64'(ms_to_ws_valid), 64'd1);
        check_val("ldb_result", 64'(ms_ld_result), 64'hFFFF_FF80);
        tick();
        data_ok = 0;
        #1 check_val("ldb_pending0", 64'(ms_pending_cnt), 64'd0);

        // three non-loads against a 4-cycle WB stall
        ws_allowin = 0;
        drive(16'h00A1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
        #1 check_val("stall_allow_e0", 64'(ms_allowin), 64'd1);
        tick();
        drive(16'h00A2, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
        #1 check_val("stall_allow_e1", 64'(ms_allowin), 64'd1);
        tick();
        drive(16'h00A3, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
        #1 check_val("stall_allow_full", 64'(ms_allowin), 64'd0);
        tick();
        #1 check_val("stall_allow_full2", 64'(ms_allowin), 64'd0);
        tick();
        ws_allowin = 1;
        #1;
        check_val("rel_allow", 64'(ms_allowin), 64'd1);
        check_val("rel_v0", 64'(ms_to_ws_valid), 64'd1);
        check_val("rel_p0", 64'(ms_payload), 64'h00A1);
        tick();
        es_valid = 0;
        #1;
        check_val("rel_v1", 64'(ms_to_ws_valid), 64'd1);
        check_val("rel_p1", 64'(ms_payload), 64'h00A2);
        tick();
        #1;
        check_val("rel_v2", 64'(ms_to_ws_valid), 64'd1);
        check_val("rel_p2", 64'(ms_payload), 64'h00A3);
        tick();
        #1 check_val("rel_empty", 64'(ms_to_ws_valid), 64'd0);

        // flush with two loads outstanding
        drive(16'h00F1, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'd0);
        tick();
        drive(16'h00F2, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'd0);
        tick();
        es_valid = 0;
        #1 check_val("fl_pending2", 64'(ms_pending_cnt), 64'd2);
        flush = 1;
        tick();
        flush = 0;
        #1;
        check_val("fl_cancel_busy", 64'(ms_cancel_busy), 64'd1);
        check_val("fl_pending0", 64'(ms_pending_cnt), 64'd0);
        drive(16'h0033, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'h1234_5678);
        tick();
        es_valid = 0;
        data_ok = 1; rdata = 32'hDEAD_0001;
        #1 check_val("fl_drop1", 64'(ms_to_ws_valid), 64'd0);
        tick();
        rdata = 32'hDEAD_0002;
        #1 check_val("fl_drop2", 64'(ms_to_ws_valid), 64'd0);
        tick();
        data_ok = 0;
        #1 check_val("fl_cancel_done", 64'(ms_cancel_busy), 64'd0);
        data_ok = 1; rdata = 32'h1234_5678;
        #1;
        check_val("fl_third_valid", 64'(ms_to_ws_valid), 64'd1);
        check_val("fl_third_result", 64'(ms_ld_result), 64'h1234_5678);
        tick();
        data_ok = 0;

        // flush coincident with data_ok, one load pending
        drive(16'h0044, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'd0);
        tick();
        es_valid = 0;
        flush = 1; data_ok = 1; rdata = 32'h5555_AAAA;
        tick();
        flush = 0; data_ok = 0;
        #1 check_val("flok_cancel", 64'(ms_cancel_busy), 64'd0);
        drive(16'h0055, 1'b1, LD_SIZE_H, 1'b1, 2'd2, 32'h0000_BEEF);
        tick();
        es_valid = 0;
        data_ok = 1; rdata = 32'hBEEF_1234;
        #1;
        check_val("flok_valid", 64'(ms_to_ws_valid), 64'd1);
        check_val("flok_result", 64'(ms_ld_result), 64'h0000_BEEF);
        tick();
        data_ok = 0;

        // empty queue: load enqueued together with its data_ok
        drive(16'h0066, 1'b1, LD_SIZE_B, 1'b0, 2'd1, 32'hFFFF_FF8F);
        data_ok = 1; rdata = 32'h0000_8F00;
        tick();
        es_valid = 0; data_ok = 0;
        #1;
        check_val("cap_pending", 64'(ms_pending_cnt), 64'd0);
        check_val("cap_valid", 64'(ms_to_ws_valid), 64'd1);
        check_val("cap_result", 64'(ms_ld_result), 64'hFFFF_FF8F);
        tick();
        // spurious response is ignored
        data_ok = 1; rdata = 32'h7777_7777;
        tick();
        data_ok = 0;
        #1;
        check_val("spur_pending", 64'(ms_pending_cnt), 64'd0);
        check_val("spur_cancel", 64'(ms_cancel_busy), 64'd0);
        check_val("spur_valid", 64'(ms_to_ws_valid), 64'd0);

        // 64-bit: ld.d then ld.hu offset 6
        v64 = 1; ld64 = 1; sz64 = LD_SIZE_D; un64 = 0; off64 = 3'd0; pay64 = 16'h0D0D;
        tick();
        sz64 = LD_SIZE_H; un64 = 1; off64 = 3'd6; pay64 = 16'h0E0E;
        ok64 = 1; rd64 = 64'h0123_4567_89AB_CDEF;
        #1;
        check_val("d64_valid", 64'(outv64), 64'd1);
        check_val("d64_result", res64, 64'h0123_4567_89AB_CDEF);
        check_val("d64_payload", 64'(opay64), 64'h0D0D);
        tick();
        v64 = 0;
        rd64 = 64'hBEEF_0000_0000_0000;
        #1;
        check_val("hu64_valid", 64'(outv64), 64'd1);
        check_val("hu64_result", res64, 64'h0000_0000_0000_BEEF);
        tick();
        ok64 = 0;
        #1 check_val("d64_pending0", 64'(pend64), 64'd0);

        // asynchronous reset while loads are pending and a cancel count is live
        drive(16'h00C1, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'd0);
        tick();
        drive(16'h00C2, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'd0);
        tick();
        es_valid = 0;
        flush = 1;
        tick();
        flush = 0;
        drive(16'h00C3, 1'b1, LD_SIZE_W, 1'b0, 2'd0, 32'd0);
        tick();
        es_valid = 0;
        #1;
        check_val("mid_cancel_busy", 64'(ms_cancel_busy), 64'd1);
        check_val("mid_pending", 64'(ms_pending_cnt), 64'd1);
        #1 resetn = 1'b0;
        #1;
        check_val("arst_valid", 64'(ms_to_ws_valid), 64'd0);
        check_val("arst_allowin", 64'(ms_allowin), 64'd1);
        check_val("arst_pending", 64'(ms_pending_cnt), 64'd0);
        check_val("arst_cancel", 64'(ms_cancel_busy), 64'd0);
        check_val("arst_result", 64'(ms_ld_result), 64'd0);
        tick();
        #1 resetn = 1'b1;
        tick();
        tick();

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        check_val("sb_pop_count", 64'(n_pops), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
